// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: collects two operands and an operator from key
// events, launches the ALU, waits (with timeout) for its result, and drives display/error.
module calc_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [3:0]  KEY_ADD = 4'hA,
  parameter logic [3:0]  KEY_SUB = 4'hB,
  parameter logic [3:0]  KEY_CLR = 4'hE,
  parameter logic [3:0]  KEY_EQ  = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig,
  input  logic [3:0] value,
  input  logic [7:0] iu_out,
  input  logic       valid,
  input  logic       alu_done,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  output logic       op_sel,
  output logic       alu_start,
  output logic       clear_entry,
  output logic [1:0] disp_sel,
  output logic       err,
  output logic       busy,
  output logic [2:0] state
);

  localparam logic [2:0] S_ENTER_A = 3'd0;
  localparam logic [2:0] S_ENTER_B = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RESULT  = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic       trig_q, trig_d;
  logic       armed_q, armed_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic [7:0] operand_a_q, operand_a_d;
  logic [7:0] operand_b_q, operand_b_d;
  logic       op_sel_q, op_sel_d;
  logic       alu_start_q, alu_start_d;
  logic       clear_entry_q, clear_entry_d;
  logic [1:0] disp_sel_q, disp_sel_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  logic key_ev, op_ev, eq_ev, clr_ev;

  // armed_q blocks the first cycle after reset so a trig level held through
  // release is absorbed into trig_q instead of reading as a fresh edge.
  always_comb begin
    key_ev = armed_q & trig & ~trig_q;
    op_ev  = key_ev & ((value == KEY_ADD) | (value == KEY_SUB));
    eq_ev  = key_ev & (value == KEY_EQ);
    clr_ev = key_ev & (value == KEY_CLR);
    trig_d  = trig;
    armed_d = 1'b1;
    wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_ENTER_A;
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      armed_q    <= armed_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic; clear overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ENTER_A: if (op_ev) state_d = valid ? S_ENTER_B : S_ERROR;
      S_ENTER_B: if (eq_ev) state_d = valid ? S_EXEC : S_ERROR;
      S_EXEC:    state_d = S_WAIT;
      S_WAIT: begin
        if (alu_done)                     state_d = S_RESULT;
        else if (wait_cnt_q == WAIT_LAST) state_d = S_ERROR;
      end
      S_RESULT, S_ERROR: state_d = state_q;
      default:   state_d = S_ENTER_A;
    endcase
    if (clr_ev) state_d = S_ENTER_A;
  end

  // Output logic: every output is a flop loaded from the upcoming state.
  always_comb begin
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    op_sel_d      = op_sel_q;
    clear_entry_d = 1'b0;
    alu_start_d   = (state_d == S_EXEC);
    busy_d        = (state_d == S_EXEC) | (state_d == S_WAIT);
    err_d         = (state_d == S_ERROR);
    case (state_d)
      S_RESULT: disp_sel_d = 2'd1;
      S_ERROR:  disp_sel_d = 2'd2;
      default:  disp_sel_d = 2'd0;
    endcase
    if (clr_ev) begin
      operand_a_d   = 8'd0;
      operand_b_d   = 8'd0;
      op_sel_d      = 1'b0;
      clear_entry_d = 1'b1;
    end else begin
      case (state_q)
        S_ENTER_A: begin
          if (op_ev && valid) begin
            operand_a_d   = iu_out;
            op_sel_d      = (value == KEY_SUB);
            clear_entry_d = 1'b1;
          end
        end
        S_ENTER_B: begin
          if (op_ev) op_sel_d = (value == KEY_SUB);
          if (eq_ev && valid) operand_b_d = iu_out;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      operand_a_q   <= 8'd0;
      operand_b_q   <= 8'd0;
      op_sel_q      <= 1'b0;
      alu_start_q   <= 1'b0;
      clear_entry_q <= 1'b0;
      disp_sel_q    <= 2'd0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      op_sel_q      <= op_sel_d;
      alu_start_q   <= alu_start_d;
      clear_entry_q <= clear_entry_d;
      disp_sel_q    <= disp_sel_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
    end
  end

  assign operand_a   = operand_a_q;
  assign operand_b   = operand_b_q;
  assign op_sel      = op_sel_q;
  assign alu_start   = alu_start_q;
  assign clear_entry = clear_entry_q;
  assign disp_sel    = disp_sel_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign state       = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed key sequences push expected output snapshots;
// a negedge monitor compares a snapshot whenever state changes or a pulse fires.
module tb_calc_sequencer;
  localparam int W = 36;
  localparam logic [3:0] K_A = 4'hA, K_B = 4'hB, K_E = 4'hE, K_F = 4'hF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trig = 1'b0;
  logic [3:0] value = 4'd0;
  logic [7:0] iu_out = 8'd0;
  logic       valid = 1'b0;
  logic       alu_done = 1'b0;
  logic [7:0] operand_a, operand_b;
  logic       op_sel, alu_start, clear_entry, err, busy;
  logic [1:0] disp_sel;
  logic [2:0] state;

  calc_sequencer dut (
    .clk(clk), .reset(reset), .trig(trig), .value(value), .iu_out(iu_out),
    .valid(valid), .alu_done(alu_done), .operand_a(operand_a), .operand_b(operand_b),
    .op_sel(op_sel), .alu_start(alu_start), .clear_entry(clear_entry),
    .disp_sel(disp_sel), .err(err), .busy(busy), .state(state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // Snapshot: {check_dwell, dwell[8:0], state, a, b, op, start, clr, disp, err, busy}
  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [7:0] a,
                                      input logic [7:0] b, input logic op,
                                      input logic start, input logic clr,
                                      input logic [1:0] disp, input logic e,
                                      input logic bsy, input logic chk,
                                      input logic [8:0] dwell);
    return {chk, dwell, st, a, b, op, start, clr, disp, e, bsy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic press(input logic [3:0] v, input logic [7:0] iu, input logic vl, input int hold);
    @(negedge clk);
    value = v; iu_out = iu; valid = vl; trig = 1'b1;
    repeat (hold) @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] target, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (state == target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_state: state %0d not reached in %0d cycles, got %0d", target, bound, state);
    end
  endtask

  // Monitor / scoreboard
  logic [2:0]  prev_state = 3'd0;
  int          dwell = 0;
  logic [25:0] obs;
  logic [W-1:0] exp_e;

  always @(negedge clk) begin
    obs = {state, operand_a, operand_b, op_sel, alu_start, clear_entry, disp_sel, err, busy};
    if (dwell < 511) dwell++;
    if (state != prev_state || alu_start || clear_entry) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", obs);
      end else begin
        exp_e = exp_q.pop_front();
        if (obs !== exp_e[25:0] || (exp_e[35] && 9'(dwell) != exp_e[34:26])) begin
          n_fail++;
          $display("FAIL snapshot: got %h dwell %0d expected %h dwell %0d",
                   obs, dwell, exp_e[25:0], exp_e[34:26]);
        end
      end
      dwell = 0;
    end
    prev_state = state;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_outputs", {operand_a, operand_b, op_sel, alu_start, clear_entry, disp_sel, err, busy}, 0);
    #2 reset = 1'b1;

    // Add 0x0C + 0xFB, ALU answers after 3 cycles
    exp_q.push_back(mk(1, 8'h0C, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_A, 8'h0C, 1, 1);
    exp_q.push_back(mk(2, 8'h0C, 8'hFB, 0, 1, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(3, 8'h0C, 8'hFB, 0, 0, 0, 0, 0, 1, 1, 1));
    press(K_F, 8'hFB, 1, 1);
    wait_state(3, 10);
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(4, 8'h0C, 8'hFB, 0, 0, 0, 1, 0, 0, 1, 3));
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    press(K_A, 8'h11, 1, 1);
    exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_E, 8'h00, 1, 1);

    // Out-of-range operand on subtract -> error, then clear
    exp_q.push_back(mk(5, 8'h00, 8'h00, 0, 0, 0, 2, 1, 0, 0, 0));
    press(K_B, 8'h80, 0, 1);
    press(4'h3, 8'h03, 1, 1);
    exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_E, 8'h00, 1, 1);

    // Operator overwrite in ENTER_B, then ALU never answers -> timeout after 255
    exp_q.push_back(mk(1, 8'h25, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_A, 8'h25, 1, 1);
    press(K_B, 8'h77, 1, 1);
    press(4'h5, 8'h05, 1, 1);
    exp_q.push_back(mk(2, 8'h25, 8'h03, 1, 1, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(3, 8'h25, 8'h03, 1, 0, 0, 0, 0, 1, 1, 1));
    press(K_F, 8'h03, 1, 1);
    wait_state(3, 10);
    exp_q.push_back(mk(5, 8'h25, 8'h03, 1, 0, 0, 2, 1, 0, 1, 255));
    wait_state(5, 400);
    exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_E, 8'h00, 1, 1);

    // alu_done in the 255th WAIT cycle -> RESULT wins
    exp_q.push_back(mk(1, 8'h7F, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_A, 8'h7F, 1, 1);
    exp_q.push_back(mk(2, 8'h7F, 8'h81, 0, 1, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(3, 8'h7F, 8'h81, 0, 0, 0, 0, 0, 1, 1, 1));
    press(K_F, 8'h81, 1, 1);
    wait_state(3, 10);
    repeat (254) @(negedge clk);
    exp_q.push_back(mk(4, 8'h7F, 8'h81, 0, 0, 0, 1, 0, 0, 1, 255));
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_E, 8'h00, 1, 1);

    // trig held 50 cycles -> one event; clear during WAIT aborts without alu_start
    exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_E, 8'h00, 1, 50);
    exp_q.push_back(mk(1, 8'h10, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_A, 8'h10, 1, 1);
    exp_q.push_back(mk(2, 8'h10, 8'h20, 0, 1, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(3, 8'h10, 8'h20, 0, 0, 0, 0, 0, 1, 1, 1));
    press(K_F, 8'h20, 1, 1);
    exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_E, 8'h00, 1, 1);
    repeat (4) @(negedge clk);

    // Reset pulse in WAIT with trig held high through release
    exp_q.push_back(mk(1, 8'h44, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_A, 8'h44, 1, 1);
    exp_q.push_back(mk(2, 8'h44, 8'h55, 0, 1, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(3, 8'h44, 8'h55, 0, 0, 0, 0, 0, 1, 1, 1));
    press(K_F, 8'h55, 1, 1);
    wait_state(3, 10);
    repeat (3) @(negedge clk);
    exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 0);
    check("async_rst_operands", {operand_a, operand_b, op_sel}, 0);
    check("async_rst_pulses", {alu_start, clear_entry}, 0);
    check("async_rst_status", {disp_sel, err, busy}, 0);
    value = K_A; iu_out = 8'h66; valid = 1'b1; trig = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (5) @(negedge clk);
    trig = 1'b0;
    repeat (3) @(negedge clk);
    check("post_release_state", 32'(state), 0);
    exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
    press(K_E, 8'h00, 1, 1);

    // Final report
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of cycles spent waiting for alu_done.
REQ-002 Parameter KEY_ADD, default 4'hA, is the key code selecting add.
REQ-003 Parameter KEY_SUB, default 4'hB, is the key code selecting subtract.
REQ-004 Parameter KEY_CLR, default 4'hE, is the key code for clear.
REQ-005 Parameter KEY_EQ, default 4'hF, is the key code for equals.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port trig, input, 1 bit: keypad key-valid level from the input unit.
REQ-009 Port value, input, 4 bits: code of the current key.
REQ-010 Port iu_out, input, 8 bits: current entry in two's complement.
REQ-011 Port valid, input, 1 bit: the current entry is in range.
REQ-012 Port alu_done, input, 1 bit: the ALU result is ready.
REQ-013 Port operand_a, output, 8 bits: latched first operand.
REQ-014 Port operand_b, output, 8 bits: latched second operand.
REQ-015 Port op_sel, output, 1 bit: selected operation; 0 is add, 1 is subtract.
REQ-016 Port alu_start, output, 1 bit: one-cycle ALU start pulse.
REQ-017 Port clear_entry, output, 1 bit: one-cycle pulse that clears the keypad digit buffer.
REQ-018 Port disp_sel, output, 2 bits: display source; 0 is entry, 1 is result, 2 is error.
REQ-019 Port err, output, 1 bit: error flag.
REQ-020 Port busy, output, 1 bit: high while in EXEC or WAIT.
REQ-021 Port state, output, 3 bits: current FSM state code.

Function
REQ-022 A key event is a 0->1 edge of trig, detected against a registered copy of trig; exactly one event per edge, with value sampled in the same cycle.
REQ-023 FSM states and codes: ENTER_A=0, ENTER_B=1, EXEC=2, WAIT=3, RESULT=4, ERROR=5; codes 6-7 return to ENTER_A on the next clock.
REQ-024 ENTER_A:
- KEY_ADD or KEY_SUB event with valid=1: latch operand_a=iu_out and op_sel (0 for ADD, 1 for SUB), pulse clear_entry, go to ENTER_B.
- Same event with valid=0: go to ERROR.
REQ-025 ENTER_B:
- KEY_EQ event with valid=1: latch operand_b=iu_out, go to EXEC.
- KEY_EQ event with valid=0: go to ERROR.
- KEY_ADD/KEY_SUB events: overwrite op_sel only; operand_a is unchanged.
REQ-026 EXEC: alu_start=1 for exactly this one cycle; unconditionally go to WAIT next cycle.
REQ-027 WAIT:
- An 8-bit counter, zeroed on entry, increments each cycle.
- alu_done=1: go to RESULT.
- Counter reaches TIMEOUT with alu_done=0: go to ERROR.
- alu_done in the same cycle as the timeout: RESULT wins.
REQ-028 RESULT: disp_sel=1; all events other than KEY_CLR are ignored.
REQ-029 ERROR: err=1, disp_sel=2; all events other than KEY_CLR are ignored.
REQ-030 A KEY_CLR event in any state: operand_a=0, operand_b=0, op_sel=0, err=0, pulse clear_entry, go to ENTER_A; this has priority over every other transition.
REQ-031 Digit and unassigned key events (0-9, C, D) cause no state change in any state.
REQ-032 disp_sel=0 in ENTER_A, ENTER_B, EXEC and WAIT.
REQ-033 busy=1 only in EXEC and WAIT.
REQ-034 Events arriving during EXEC or WAIT are ignored, except KEY_CLR, which aborts the operation with no further alu_start.
REQ-035 All outputs are registered; alu_start and clear_entry are never high for more than one consecutive cycle.

Reset
REQ-036 reset=0 asynchronously forces:
- state=ENTER_A;
- operand_a=0, operand_b=0, op_sel=0;
- alu_start=0, clear_entry=0;
- disp_sel=0, err=0, busy=0;
- WAIT counter and trig edge register cleared.
REQ-037 Reset asserted mid-operation (including WAIT) aborts it with no pulse generated.
REQ-038 After release, the first rising clock edge behaves as in ENTER_A; trig held high through release produces no event.

Verification
REQ-039 Sequence: iu_out=8'h0C valid=1 key A; iu_out=8'hFB key F; alu_done after 3 cycles -> operand_a=0x0C, operand_b=0xFB, op_sel=0, one alu_start pulse, then state=4, disp_sel=1.
REQ-040 Key B with valid=0 in ENTER_A -> state=5, err=1, disp_sel=2; then key E -> state=0, err=0, one clear_entry pulse.
REQ-041 alu_done held 0 in WAIT -> ERROR after exactly TIMEOUT=255 cycles; alu_done asserted in cycle 255 -> RESULT instead.
REQ-042 Key A then key B in ENTER_B, then key F -> op_sel=1 and operand_a unchanged.
REQ-043 trig held high for 50 cycles -> exactly one event; key E during WAIT -> ENTER_A with no alu_start.
REQ-044 Reset pulsed low in WAIT -> all outputs immediately at reset values; trig high through release -> no event.
